// File: rtl/bp_fe_queue_enq_if.sv
// FE->BE queue message format and the handshake bundle that carries fetch
// results into the enqueue block and queue messages out to the BE.
package bp_fe_queue_pkg;

  localparam int vaddr_width_p               = 39;
  localparam int branch_metadata_fwd_width_p = 36;

  typedef enum logic [2:0] {
    e_instr_fetch        = 3'd0,
    e_itlb_miss          = 3'd1,
    e_instr_page_fault   = 3'd2,
    e_instr_access_fault = 3'd3,
    e_icache_miss        = 3'd4
  } bp_fe_msg_type_e;

  typedef struct packed {
    bp_fe_msg_type_e                        msg_type;
    logic [vaddr_width_p-1:0]               pc;
    logic [31:0]                            instr;
    logic                                   partial;
    logic [branch_metadata_fwd_width_p-1:0] branch_metadata_fwd;
  } bp_fe_queue_s;

  localparam int fe_queue_width_lp = $bits(bp_fe_queue_s);

endpackage

interface bp_fe_queue_enq_if;
  import bp_fe_queue_pkg::*;

  logic                                   flush;
  logic                                   fetch_v;
  logic                                   fetch_ready_and;
  logic [vaddr_width_p-1:0]               fetch_pc;
  logic [31:0]                            fetch_instr;
  logic                                   fetch_partial;
  logic [branch_metadata_fwd_width_p-1:0] fetch_br_metadata;
  logic                                   fetch_itlb_miss;
  logic                                   fetch_instr_page_fault;
  logic                                   fetch_instr_access_fault;
  logic                                   fetch_icache_miss;
  logic [fe_queue_width_lp-1:0]           fe_queue;
  logic                                   fe_queue_v;
  logic                                   fe_queue_ready_and;

  // The enqueue block is the message source.
  modport master (
    input  flush, fetch_v, fetch_pc, fetch_instr, fetch_partial, fetch_br_metadata,
           fetch_itlb_miss, fetch_instr_page_fault, fetch_instr_access_fault,
           fetch_icache_miss, fe_queue_ready_and,
    output fetch_ready_and, fe_queue, fe_queue_v
  );

  modport slave (
    output flush, fetch_v, fetch_pc, fetch_instr, fetch_partial, fetch_br_metadata,
           fetch_itlb_miss, fetch_instr_page_fault, fetch_instr_access_fault,
           fetch_icache_miss, fe_queue_ready_and,
    input  fetch_ready_and, fe_queue, fe_queue_v
  );

endinterface

// File: rtl/bp_fe_queue_enq.sv
// FE-side transmitter of the FE->BE queue: forms messages from fetch results,
// buffers two of them, and locks fetch after any exception until a redirect.
module bp_fe_queue_enq
  import bp_fe_queue_pkg::*;
(
  input logic               clk_i,
  input logic               reset_n_i,
  bp_fe_queue_enq_if.master fe
);

  localparam int els_lp = 2;

  typedef enum logic {
    e_run,
    e_locked
  } lock_state_e;

  lock_state_e  state;
  logic [1:0]   wptr;
  logic [1:0]   rptr;
  bp_fe_queue_s mem [els_lp];
  bp_fe_queue_s msg;
  logic         empty;
  logic         full;
  logic         enq;
  logic         deq;

  // Pointer bit 1 is the wrap bit; bit 0 selects the entry.
  assign empty = (wptr == rptr);
  assign full  = (wptr[0] == rptr[0]) && (wptr[1] != rptr[1]);

  assign fe.fetch_ready_and = reset_n_i & ~full & (state == e_run) & ~fe.flush;
  assign enq                = fe.fetch_v & fe.fetch_ready_and;

  assign fe.fe_queue_v = ~empty;
  assign deq           = fe.fe_queue_v & fe.fe_queue_ready_and;
  // Empty slots are never exposed, so the unreset storage cannot leak out.
  assign fe.fe_queue   = empty ? '0 : mem[rptr[0]];

  always_comb begin
    // NOTE: default every field first so no path leaves msg unassigned (no latch).
    msg                     = '0;
    msg.pc                  = fe.fetch_pc;
    msg.partial             = fe.fetch_partial;
    msg.branch_metadata_fwd = fe.fetch_br_metadata;
    if (fe.fetch_itlb_miss) begin
      msg.msg_type = e_itlb_miss;
    end else if (fe.fetch_instr_page_fault) begin
      msg.msg_type = e_instr_page_fault;
    end else if (fe.fetch_instr_access_fault) begin
      msg.msg_type = e_instr_access_fault;
    end else if (fe.fetch_icache_miss) begin
      msg.msg_type = e_icache_miss;
    end else begin
      msg.msg_type = e_instr_fetch;
      msg.instr    = fe.fetch_instr;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= e_run;
      wptr  <= '0;
      rptr  <= '0;
    end else if (fe.flush) begin
      // Fetch is blocked during flush, so discarding is just catching rptr up.
      state <= e_run;
      rptr  <= wptr;
    end else begin
      if (enq) wptr <= wptr + 2'd1;
      if (deq) rptr <= rptr + 2'd1;
      if (enq && (msg.msg_type != e_instr_fetch)) state <= e_locked;
    end
  end

  // NOTE: payload storage is deliberately not reset; validity lives in the pointers.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr[0]] <= msg;
  end

endmodule

// File: tb/tb_bp_fe_queue_enq.sv
// Directed bench for bp_fe_queue_enq: hand-computed expectations for reset,
// ordering, full/wrap, exception lock, flush and async reset behaviour.
module tb_bp_fe_queue_enq;
  import bp_fe_queue_pkg::*;

  logic clk_i = 1'b0;
  logic reset_n_i;
  int   n_cmp = 0;
  int   n_err = 0;

  bp_fe_queue_enq_if bus ();
  bp_fe_queue_s      q;

  bp_fe_queue_enq dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .fe        (bus.master)
  );

  assign q = bus.fe_queue;

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // flags = {itlb_miss, page_fault, access_fault, icache_miss}
  task automatic drive(input logic v, input logic [38:0] pc, input logic [31:0] instr,
                       input logic [3:0] flags);
    bus.fetch_v                  = v;
    bus.fetch_pc                 = pc;
    bus.fetch_instr              = instr;
    bus.fetch_itlb_miss          = flags[3];
    bus.fetch_instr_page_fault   = flags[2];
    bus.fetch_instr_access_fault = flags[1];
    bus.fetch_icache_miss        = flags[0];
    #1;
  endtask

  logic [3:0]  pri_flags [3];
  logic [2:0]  pri_type  [3];

  initial begin
    pri_flags[0] = 4'b0111; pri_type[0] = 3'd2;
    pri_flags[1] = 4'b0011; pri_type[1] = 3'd3;
    pri_flags[2] = 4'b0001; pri_type[2] = 3'd4;

    reset_n_i              = 1'b0;
    bus.flush              = 1'b0;
    bus.fe_queue_ready_and = 1'b0;
    bus.fetch_partial      = 1'b0;
    bus.fetch_br_metadata  = '0;
    drive(1'b0, '0, '0, 4'b0);
    #2;
    check("rst_v", 64'(bus.fe_queue_v), 64'd0);
    check("rst_q", 64'(bus.fe_queue != '0), 64'd0);
    check("rst_ready", 64'(bus.fetch_ready_and), 64'd0);
    tick();
    tick();
    reset_n_i = 1'b1;
    #1;
    check("post_rst_ready", 64'(bus.fetch_ready_and), 64'd1);
    check("post_rst_v", 64'(bus.fe_queue_v), 64'd0);

    // Single fetch, registered one cycle later.
    bus.fetch_partial     = 1'b1;
    bus.fetch_br_metadata = 36'h1_2345_6789;
    drive(1'b1, 39'h80000000, 32'h13, 4'b0);
    check("t1_ready", 64'(bus.fetch_ready_and), 64'd1);
    check("t1_no_bypass", 64'(bus.fe_queue_v), 64'd0);
    tick();
    drive(1'b0, '0, '0, 4'b0);
    bus.fetch_partial     = 1'b0;
    bus.fetch_br_metadata = '0;
    check("t1_v", 64'(bus.fe_queue_v), 64'd1);
    check("t1_type", 64'(q.msg_type), 64'd0);
    check("t1_pc", 64'(q.pc), 64'h80000000);
    check("t1_instr", 64'(q.instr), 64'h13);
    check("t1_partial", 64'(q.partial), 64'd1);
    check("t1_meta", 64'(q.branch_metadata_fwd), 64'h1_2345_6789);
    bus.fe_queue_ready_and = 1'b1;
    tick();
    check("t1_drained", 64'(bus.fe_queue_v), 64'd0);

    // Fill both entries with BE stalled, third is refused, then drain across wrap.
    bus.fe_queue_ready_and = 1'b0;
    drive(1'b1, 39'h0, 32'h13, 4'b0);
    check("t3_rdy0", 64'(bus.fetch_ready_and), 64'd1);
    tick();
    drive(1'b1, 39'h4, 32'h13, 4'b0);
    check("t3_rdy1", 64'(bus.fetch_ready_and), 64'd1);
    tick();
    drive(1'b1, 39'h8, 32'h13, 4'b0);
    check("t3_full_rdy", 64'(bus.fetch_ready_and), 64'd0);
    tick();
    drive(1'b0, '0, '0, 4'b0);
    bus.fe_queue_ready_and = 1'b1;
    check("t3_head0", 64'(q.pc), 64'h0);
    tick();
    check("t3_head1", 64'(q.pc), 64'h4);
    drive(1'b1, 39'h8, 32'h13, 4'b0);
    check("t3_refetch_rdy", 64'(bus.fetch_ready_and), 64'd1);
    tick();
    drive(1'b0, '0, '0, 4'b0);
    check("t3_head2", 64'(q.pc), 64'h8);
    check("t3_head2_v", 64'(bus.fe_queue_v), 64'd1);
    tick();
    check("t3_empty", 64'(bus.fe_queue_v), 64'd0);

    // ITLB miss outranks I$ miss, then fetch stays locked until flush.
    bus.fe_queue_ready_and = 1'b0;
    drive(1'b1, 39'h1000, 32'hdeadbeef, 4'b1001);
    check("t4_rdy", 64'(bus.fetch_ready_and), 64'd1);
    tick();
    drive(1'b1, 39'h1004, 32'h13, 4'b0);
    check("t4_locked_rdy", 64'(bus.fetch_ready_and), 64'd0);
    check("t4_type", 64'(q.msg_type), 64'd1);
    check("t4_instr", 64'(q.instr), 64'd0);
    check("t4_pc", 64'(q.pc), 64'h1000);
    bus.fe_queue_ready_and = 1'b1;
    tick();
    check("t4_drained", 64'(bus.fe_queue_v), 64'd0);
    check("t4_still_locked", 64'(bus.fetch_ready_and), 64'd0);
    tick();
    check("t4_still_locked2", 64'(bus.fe_queue_v | bus.fetch_ready_and), 64'd0);
    bus.flush = 1'b1;
    #1;
    check("t4_flush_rdy", 64'(bus.fetch_ready_and), 64'd0);
    tick();
    bus.flush = 1'b0;
    drive(1'b1, 39'h2000, 32'h13, 4'b0);
    check("t4_unlocked_rdy", 64'(bus.fetch_ready_and), 64'd1);
    tick();
    drive(1'b0, '0, '0, 4'b0);
    check("t4_new_pc", 64'(q.pc), 64'h2000);
    check("t4_new_type", 64'(q.msg_type), 64'd0);
    tick();
    check("t4_new_drained", 64'(bus.fe_queue_v), 64'd0);

    // Remaining exception priorities, each cleared by a one-cycle flush.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 39'h3000 + 39'(i * 4), 32'hffffffff, pri_flags[i]);
      tick();
      drive(1'b0, '0, '0, 4'b0);
      check($sformatf("pri%0d_type", i), 64'(q.msg_type), 64'(pri_type[i]));
      check($sformatf("pri%0d_instr", i), 64'(q.instr), 64'd0);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      #1;
      check($sformatf("pri%0d_unlock", i), 64'(bus.fetch_ready_and), 64'd1);
    end

    // Flush with two buffered: head handshake completes, second entry discarded.
    bus.fe_queue_ready_and = 1'b0;
    drive(1'b1, 39'h100, 32'h13, 4'b0);
    tick();
    drive(1'b1, 39'h104, 32'h13, 4'b0);
    tick();
    drive(1'b0, '0, '0, 4'b0);
    bus.fe_queue_ready_and = 1'b1;
    bus.flush              = 1'b1;
    #1;
    check("t5_head_v", 64'(bus.fe_queue_v), 64'd1);
    check("t5_head_pc", 64'(q.pc), 64'h100);
    tick();
    bus.flush = 1'b0;
    #1;
    check("t5_flushed", 64'(bus.fe_queue_v), 64'd0);

    // Asynchronous reset mid-cycle with one locked entry buffered.
    bus.fe_queue_ready_and = 1'b0;
    drive(1'b1, 39'h200, 32'h13, 4'b1000);
    tick();
    drive(1'b0, '0, '0, 4'b0);
    check("t6_v_before", 64'(bus.fe_queue_v), 64'd1);
    check("t6_locked", 64'(bus.fetch_ready_and), 64'd0);
    #1;
    reset_n_i = 1'b0;
    #1;
    check("t6_async_v", 64'(bus.fe_queue_v), 64'd0);
    check("t6_async_q", 64'(bus.fe_queue != '0), 64'd0);
    tick();
    reset_n_i = 1'b1;
    #1;
    check("t6_run_rdy", 64'(bus.fetch_ready_and), 64'd1);
    check("t6_empty", 64'(bus.fe_queue_v), 64'd0);
    tick();
    check("t6_empty2", 64'(bus.fe_queue_v), 64'd0);

    // Streaming: enqueue and dequeue every cycle.
    bus.fe_queue_ready_and = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 39'(i * 4), 32'h13, 4'b0);
      check($sformatf("s%0d_rdy", i), 64'(bus.fetch_ready_and), 64'd1);
      if (i > 0) begin
        check($sformatf("s%0d_v", i), 64'(bus.fe_queue_v), 64'd1);
        check($sformatf("s%0d_pc", i), 64'(q.pc), 64'((i - 1) * 4));
      end
      tick();
    end
    drive(1'b0, '0, '0, 4'b0);
    check("s_last_v", 64'(bus.fe_queue_v), 64'd1);
    check("s_last_pc", 64'(q.pc), 64'h24);
    tick();
    check("s_drained", 64'(bus.fe_queue_v), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
